// File: rtl/pie_pkg.sv
// Shared types and constants for the PIE preamble/symbol decoder and its benches.
package pie_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int CNT_SAT   = 2500;

    typedef enum logic [2:0] {
        IDLE,
        DELIM,
        DATA0,
        RTCAL,
        TRCAL,
        DATA
    } pie_state_e;

endpackage

// File: rtl/pie_edge_sync.sv
// Two-flop synchroniser for an asynchronous envelope plus single-cycle rise/fall detect.
module pie_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/pie_symbol_decoder.sv
// EPC Gen2 PIE decoder: delimiter, data-0, RTcal, optional TRcal, then data bits.
// Define PIE_TRCAL_EN to include the TRcal measurement state.
module pie_symbol_decoder
    import pie_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DELIM_MIN = 16,
    parameter int DELIM_MAX = 400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             demod_in,
    input  logic [CNT_W-1:0] count,
    input  logic             overflow,
    output logic             cnt_clear,
    output logic             cnt_enable,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [CNT_W-1:0] rtcal,
    output logic [CNT_W-1:0] trcal,
    output logic             trcal_valid,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] DMIN = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] DMAX = CNT_W'(DELIM_MAX);
`ifdef PIE_TRCAL_EN
    localparam pie_state_e AFTER_RT = TRCAL;
`else
    localparam pie_state_e AFTER_RT = DATA;
`endif

    function automatic logic decode_bit(input logic [CNT_W-1:0] iv, input logic [CNT_W-1:0] piv);
        return iv > piv;
    endfunction

    logic rise, fall, timeout;
    pie_state_e state_q, state_d;
    logic [CNT_W-1:0] d0_q, d0_d, pivot_q, pivot_d, rtcal_q, rtcal_d;
    logic cnt_clear_q, cnt_clear_d, cnt_enable_q;
    logic bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
    logic frame_done_q, frame_done_d, bit_seen_q, bit_seen_d;
`ifdef PIE_TRCAL_EN
    logic [CNT_W-1:0] trcal_q, trcal_d;
    logic trcal_valid_q, trcal_valid_d;
`endif

    pie_edge_sync u_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (demod_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // During the clear cycle the counter still shows the previous frame's saturated value.
    assign timeout = overflow & ~cnt_clear_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && timeout) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (fall) state_d = DELIM;
                DELIM:   if (rise) state_d = (count >= DMIN && count <= DMAX) ? DATA0 : IDLE;
                DATA0:   if (rise) state_d = RTCAL;
                RTCAL:   if (rise) state_d = (count > d0_q) ? AFTER_RT : IDLE;
                TRCAL:   if (rise) state_d = DATA;
                DATA:    state_d = DATA;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_clear_d  = 1'b0;
        bit_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        bit_out_d    = bit_out_q;
        bit_seen_d   = bit_seen_q;
        d0_d         = d0_q;
        pivot_d      = pivot_q;
        rtcal_d      = rtcal_q;
`ifdef PIE_TRCAL_EN
        trcal_d       = trcal_q;
        trcal_valid_d = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (fall) begin
                cnt_clear_d = 1'b1;
                bit_seen_d  = 1'b0;
            end
        end else if (timeout) begin
            frame_done_d = bit_seen_q;
        end else if (rise) begin
            cnt_clear_d = 1'b1;
            case (state_q)
                DATA0: d0_d = count;
                RTCAL: begin
                    if (count > d0_q) begin
                        rtcal_d = count;
                        pivot_d = count >> 1;
                    end
                end
`ifdef PIE_TRCAL_EN
                TRCAL: begin
                    if (count > rtcal_q) begin
                        trcal_d       = count;
                        trcal_valid_d = 1'b1;
                    end else begin
                        bit_out_d   = decode_bit(count, pivot_q);
                        bit_valid_d = 1'b1;
                        bit_seen_d  = 1'b1;
                    end
                end
`endif
                DATA: begin
                    bit_out_d   = decode_bit(count, pivot_q);
                    bit_valid_d = 1'b1;
                    bit_seen_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_clear_q  <= 1'b0;
            cnt_enable_q <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            bit_seen_q   <= 1'b0;
            d0_q         <= '0;
            pivot_q      <= '0;
            rtcal_q      <= '0;
        end else begin
            cnt_clear_q  <= cnt_clear_d;
            cnt_enable_q <= (state_q != IDLE);
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            bit_seen_q   <= bit_seen_d;
            d0_q         <= d0_d;
            pivot_q      <= pivot_d;
            rtcal_q      <= rtcal_d;
        end
    end

`ifdef PIE_TRCAL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            trcal_q       <= '0;
            trcal_valid_q <= 1'b0;
        end else begin
            trcal_q       <= trcal_d;
            trcal_valid_q <= trcal_valid_d;
        end
    end

    assign trcal       = trcal_q;
    assign trcal_valid = trcal_valid_q;
`else
    assign trcal       = '0;
    assign trcal_valid = 1'b0;
`endif

    assign cnt_clear  = cnt_clear_q;
    assign cnt_enable = cnt_enable_q;
    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign rtcal      = rtcal_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pie_symbol_decoder.sv
// Bench for pie_symbol_decoder: saturating counter model, PIE waveform driver, frame-level reference.
module tb_pie_symbol_decoder;
    import pie_pkg::*;

    localparam int DMIN = 16;
    localparam int DMAX = 400;
    localparam int PW   = 12;  // data-pulse low width; as a delimiter it measures 10 and is rejected

    logic        clk = 1'b0;
    logic        reset;
    logic        demod_in;
    logic [15:0] count;
    logic        overflow;
    logic        cnt_clear, cnt_enable, bit_out, bit_valid, trcal_valid, frame_done;
    logic [15:0] rtcal, trcal;

    always #5 clk = ~clk;

    pie_symbol_decoder #(.CNT_W(16), .DELIM_MIN(DMIN), .DELIM_MAX(DMAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .demod_in    (demod_in),
        .count       (count),
        .overflow    (overflow),
        .cnt_clear   (cnt_clear),
        .cnt_enable  (cnt_enable),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .rtcal       (rtcal),
        .trcal       (trcal),
        .trcal_valid (trcal_valid),
        .frame_done  (frame_done)
    );

    // Interval counter the decoder drives: clear wins, saturates one past CNT_SAT.
    always_ff @(posedge clk) begin
        if (reset)                                    count <= '0;
        else if (cnt_clear)                           count <= '0;
        else if (cnt_enable && count <= 16'(CNT_SAT)) count <= count + 16'd1;
    end
    assign overflow = (count > 16'(CNT_SAT));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] obs_bits[$];
    logic [31:0] obs_tr[$];
    int          obs_fd;
    int          rt_hold;
    int          tr_hold;

    always @(negedge clk) begin
        if (!reset) begin
            if (bit_valid)   obs_bits.push_back(32'(bit_out));
            if (trcal_valid) obs_tr.push_back(32'(trcal));
            if (frame_done)  obs_fd = obs_fd + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: a count of N at a rise is a rise-to-rise spacing of N cycles of counting.
    task automatic model_frame(input int delim, input int iv[$],
                               output int ebits[$], output int etr[$], output int efd);
        int pivot;
        int k;
        ebits = {};
        etr   = {};
        efd   = 0;
        if (delim < DMIN || delim > DMAX || iv.size() < 2) return;
        if (iv[1] <= iv[0]) return;
        rt_hold = iv[1];
        pivot   = iv[1] / 2;
        k       = 2;
`ifdef PIE_TRCAL_EN
        if (iv.size() > 2 && iv[2] > iv[1]) begin
            etr.push_back(iv[2]);
            tr_hold = iv[2];
            k = 3;
        end
`endif
        for (int i = k; i < iv.size(); i++) ebits.push_back((iv[i] > pivot) ? 1 : 0);
        efd = (ebits.size() > 0) ? 1 : 0;
    endtask

    // Two synchroniser cycles of latency plus one clear cycle: low L measures L-2, spacing P measures P-2.
    task automatic drive_frame(input int delim, input int iv[$]);
        repeat (4) @(negedge clk);
        demod_in = 1'b0;
        repeat (delim + 2) @(negedge clk);
        demod_in = 1'b1;
        foreach (iv[i]) begin
            repeat (iv[i] + 2 - PW) @(negedge clk);
            demod_in = 1'b0;
            repeat (PW) @(negedge clk);
            demod_in = 1'b1;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int delim, input int iv[$], input bit wait_to);
        int ebits[$];
        int etr[$];
        int efd;
        obs_bits = {};
        obs_tr   = {};
        obs_fd   = 0;
        model_frame(delim, iv, ebits, etr, efd);
        drive_frame(delim, iv);
        if (wait_to) repeat (2600) @(negedge clk);
        check({tag, " nbits"}, obs_bits.size(), ebits.size());
        for (int i = 0; i < ebits.size() && i < obs_bits.size(); i++)
            check($sformatf("%s bit%0d", tag, i), obs_bits[i], ebits[i]);
        check({tag, " ntrcal"}, obs_tr.size(), etr.size());
        for (int i = 0; i < etr.size() && i < obs_tr.size(); i++)
            check($sformatf("%s trcal%0d", tag, i), obs_tr[i], etr[i]);
        check({tag, " rtcal"}, 32'(rtcal), rt_hold);
        check({tag, " trcal_hold"}, 32'(trcal), tr_hold);
        check({tag, " frame_done"}, obs_fd, efd);
        check({tag, " cnt_enable"}, 32'(cnt_enable), 0);
        if (ebits.size() > 0) check({tag, " bit_hold"}, 32'(bit_out), ebits[ebits.size()-1]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cnt_clear"}, 32'(cnt_clear), 0);
        check({tag, " cnt_enable"}, 32'(cnt_enable), 0);
        check({tag, " bit_out"}, 32'(bit_out), 0);
        check({tag, " bit_valid"}, 32'(bit_valid), 0);
        check({tag, " rtcal"}, 32'(rtcal), 0);
        check({tag, " trcal"}, 32'(trcal), 0);
        check({tag, " trcal_valid"}, 32'(trcal_valid), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int q[$];
        reset    = 1'b1;
        demod_in = 1'b1;
        rt_hold  = 0;
        tr_hold  = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        q = {100, 250, 400, 100, 200, 125, 126};
        run_frame("query", 50, q, 1'b1);

        q = {100, 250, 110, 240};
        run_frame("no_trcal", DMIN, q, 1'b1);

        q = {100, 250, 400, 100, 200};
        run_frame("short_delim", 10, q, 1'b0);

        q = {100, 250, 60, 200, 90};
        run_frame("timeout3", DMAX, q, 1'b1);

        q = {100, 300};
        run_frame("timeout0", 50, q, 1'b1);

        q = {100, 90, 150, 200};
        run_frame("bad_rtcal", 50, q, 1'b0);

        // Reset while data bits are being decoded, then a clean frame.
        q = {100, 250, 400, 100, 200};
        drive_frame(50, q);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset   = 1'b0;
        rt_hold = 0;
        tr_hold = 0;
        q = {100, 250, 400, 100, 200, 125, 126};
        run_frame("after_reset", 50, q, 1'b1);

        for (int f = 0; f < 6; f++) begin
            int iv[$];
            int delim, d0, rt, nd, r, half;
            r = int'($urandom_range(0, 5));
            if (r == 0)      delim = int'($urandom_range(5, DMIN - 1));
            else if (r == 1) delim = int'($urandom_range(DMAX + 1, DMAX + 20));
            else             delim = int'($urandom_range(DMIN, DMAX));
            d0 = int'($urandom_range(30, 200));
            if ($urandom_range(0, 5) == 0) rt = int'($urandom_range(20, d0));
            else                           rt = int'($urandom_range(d0 + 1, 2 * d0 + 100));
            iv = {d0, rt};
            if ($urandom_range(0, 1) == 1) iv.push_back(int'($urandom_range(rt + 1, rt + 400)));
            half = (rt / 2 < 20) ? 20 : rt / 2;
            nd = int'($urandom_range(0, 5));
            for (int j = 0; j < nd; j++) begin
                case ($urandom_range(0, 3))
                    0:       iv.push_back(half);
                    1:       iv.push_back(half + 1);
                    default: iv.push_back(int'($urandom_range(20, rt + 50)));
                endcase
            end
            run_frame($sformatf("rnd%0d", f), delim, iv, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pie_symbol_decoder.md
Name: pie_symbol_decoder

Overview:
- Downstream consumer of the tag's 16-bit saturating interval counter (saturates at count > 2500, overflow flag).
- Synchronises the demodulated reader envelope and drives the counter's clear/enable.
- Measures rising-edge-to-rising-edge intervals and decodes the EPC Gen2 PIE preamble: delimiter, data-0, RTcal, optional TRcal.
- Emits data bits to the command parser, plus a frame-done pulse when the counter times out.

Parameters:
- CNT_W, 16, width of the count input and of stored interval registers.
- DELIM_MIN, 16, minimum accepted delimiter low time in cycles (inclusive).
- DELIM_MAX, 400, maximum accepted delimiter low time in cycles (inclusive).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- demod_in  in  1  raw demodulator output, asynchronous; low = reader pulse.
- count  in  CNT_W  interval counter value.
- overflow  in  1  interval counter saturation/timeout flag.
- cnt_clear  out  1  registered one-cycle clear pulse to the counter.
- cnt_enable  out  1  counter enable, registered.
- bit_out  out  1  decoded data bit; valid with bit_valid.
- bit_valid  out  1  one-cycle strobe per decoded bit.
- rtcal  out  CNT_W  latched RTcal interval.
- trcal  out  CNT_W  latched TRcal interval.
- trcal_valid  out  1  one-cycle strobe when TRcal is latched.
- frame_done  out  1  one-cycle strobe at end of frame (timeout after at least one bit).

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high (ports clk, reset).
  - All outputs and registers reset to 0; state resets to IDLE.
  - Reset mid-frame aborts without any strobes.
- Input synchroniser and edge detect:
  - demod_in passes through a 2-FF synchroniser, then a previous-value register.
  - fall/rise are single-cycle detects, 2 cycles after the demod_in transition.
- Measurement:
  - Interval = count sampled in the rise-detect cycle.
  - cnt_clear pulses in the following cycle.
- Counter enable:
  - cnt_enable = 1 in every state except IDLE.
  - Entering IDLE deasserts it the next cycle.
- States:
  - IDLE: on fall → pulse cnt_clear, go DELIM.
  - DELIM: on rise → if DELIM_MIN ≤ count ≤ DELIM_MAX, go DATA0; else go IDLE. Clear the counter in both cases.
  - DATA0: on rise → latch d0 = count, go RTCAL.
  - RTCAL: on rise → if count > d0, latch rtcal and pivot = rtcal >> 1 (floor), go TRCAL; else go IDLE (malformed preamble).
  - TRCAL: on rise → if count > rtcal, latch trcal, pulse trcal_valid, go DATA. Otherwise the interval is the first data bit: emit bit, go DATA.
  - DATA: on rise → bit_out = (count > pivot), bit_valid = 1 for one cycle. An interval equal to pivot decodes as 0.
- Timeout:
  - overflow = 1 in any non-IDLE state → go IDLE.
  - frame_done pulses only if at least one bit was emitted this frame.
  - overflow has priority over a rise in the same cycle; no bit is emitted for that interval.
- Output hold:
  - rtcal and trcal hold their values until the next successful latch or reset.
  - bit_out holds its last value between strobes.
- Falls outside IDLE are ignored; only rises delimit intervals.

Optional Feature:
- PIE_TRCAL_EN
  - Defined: TRCAL state present as described.
  - Undefined: RTCAL goes directly to DATA. trcal and trcal_valid are tied to 0, and every post-RTcal interval is a data bit.

Decomposition:
- Shared package pie_pkg:
  - state enum (IDLE, DELIM, DATA0, RTCAL, TRCAL, DATA).
  - CNT_W default constant.
  - counter saturation constant 2500 for benches.
- One natural sub-module: pie_edge_sync (2-FF synchroniser plus rise/fall detect), reusable by other envelope consumers.

Test Plan:
- Full query preamble with PIE_TRCAL_EN. Stimulus: delimiter low 50 cycles; intervals d0 = 100, rtcal = 250, trcal = 400; then data intervals 100, 200, 125, 126. Required: rtcal = 250, pivot = 125, trcal_valid once with trcal = 400, bits 0, 1, 0, 1.
- Same preamble without TRcal. Stimulus: interval 110 after RTcal. Required: no trcal_valid; first bit = 0. Next interval 240 → bit 1.
- Short delimiter. Stimulus: low 10 cycles, then valid-looking intervals. Required: return to IDLE; no bit_valid or trcal_valid ever.
- Timeout. Stimulus: stop edges after 3 bits. Required: frame_done exactly once when overflow rises (count 2501), cnt_enable drops, state IDLE. Repeat with 0 bits: no frame_done.
- Reset mid-frame. Stimulus: assert reset for 1 cycle during DATA. Required: all outputs 0 next cycle; a following valid frame decodes correctly.
- Malformed RTcal. Stimulus: rtcal = 90 with d0 = 100. Required: IDLE; rtcal output keeps its previous value.
